// File: rtl/w2i_pkg.sv
// Shared types and constants for the writeback-to-decode return stage.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 32'h8000_0000
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0000_0000
`endif

package w2i_pkg;

  localparam int REG_AW = 5;
  localparam int DW     = `DATA_WIDTH;
  localparam int AW     = `ADDR_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } w2i_state_e;

  typedef struct packed {
    logic [AW-1:0]     pc;
    logic              wr_en;
    logic [REG_AW-1:0] wr_id;
    logic [DW-1:0]     wr_data;
  } w2i_entry_t;

  localparam w2i_entry_t W2I_ENTRY_RST = '{
    pc:      `ADDR_INIT,
    wr_en:   1'b0,
    wr_id:   {REG_AW{1'b0}},
    wr_data: `DATA_ZERO
  };

endpackage

// File: rtl/w2i_fwd_sel.sv
// Two-candidate forwarding compare with newest-wins priority (SKID over MAIN).
module w2i_fwd_sel
  import w2i_pkg::*;
(
  input  logic [REG_AW-1:0] rs_id,
  input  logic              main_vld,
  input  logic              main_wr_en,
  input  logic [REG_AW-1:0] main_wr_id,
  input  logic [DW-1:0]     main_wr_data,
  input  logic              skid_vld,
  input  logic              skid_wr_en,
  input  logic [REG_AW-1:0] skid_wr_id,
  input  logic [DW-1:0]     skid_wr_data,
  output logic              hit,
  output logic [DW-1:0]     data
);

  logic rs_nonzero_s;
  logic main_q_s;
  logic skid_q_s;

  // Qualify each candidate; x0 never forwards and invalid entries never match.
  always_comb begin
    rs_nonzero_s = (rs_id != {REG_AW{1'b0}});
    main_q_s     = main_vld && main_wr_en && (main_wr_id == rs_id) && rs_nonzero_s;
    skid_q_s     = skid_vld && skid_wr_en && (skid_wr_id == rs_id) && rs_nonzero_s;
  end

  // Priority select: the newer SKID entry shadows MAIN.
  always_comb begin
    hit  = 1'b0;
    data = `DATA_ZERO;
    if (skid_q_s) begin
      hit  = 1'b1;
      data = skid_wr_data;
    end else if (main_q_s) begin
      hit  = 1'b1;
      data = main_wr_data;
    end else begin
      hit  = 1'b0;
      data = `DATA_ZERO;
    end
  end

endmodule

// File: rtl/wbu2idu.sv
// Writeback-to-decode return stage: two-entry skid buffer plus forwarding lookup.
module wbu2idu
  import w2i_pkg::*;
(
  input  logic              i_sys_clk,
  input  logic              i_sys_rst_n,
  input  logic              i_wbu_valid,
  output logic              o_w2i_ready,
  input  logic [AW-1:0]     i_wbu_pc,
  input  logic              i_wbu_reg_wr_en,
  input  logic [REG_AW-1:0] i_wbu_reg_wr_id,
  input  logic [DW-1:0]     i_wbu_reg_wr_data,
  input  logic              i_idu_ready,
  output logic              o_w2i_valid,
  output logic [AW-1:0]     o_w2i_pc,
  output logic              o_w2i_reg_wr_en,
  output logic [REG_AW-1:0] o_w2i_reg_wr_id,
  output logic [DW-1:0]     o_w2i_reg_wr_data,
  input  logic [REG_AW-1:0] i_idu_rs1_id,
  input  logic [REG_AW-1:0] i_idu_rs2_id,
  output logic              o_w2i_rs1_hit,
  output logic              o_w2i_rs2_hit,
  output logic [DW-1:0]     o_w2i_rs1_data,
  output logic [DW-1:0]     o_w2i_rs2_data
);

  w2i_state_e state_r, state_nxt_s;
  w2i_entry_t main_r, main_nxt_s;
  w2i_entry_t skid_r, skid_nxt_s;
  w2i_entry_t in_ent_s;
  logic       in_fire_s;
  logic       out_fire_s;
  logic       main_vld_s;
  logic       skid_vld_s;

  // Handshake decode; ready depends on state only so IDU never stalls WBU combinationally.
  always_comb begin
    o_w2i_ready = (state_r != FULL);
    o_w2i_valid = (state_r != EMPTY);
    main_vld_s  = (state_r != EMPTY);
    skid_vld_s  = (state_r == FULL);
    in_fire_s   = i_wbu_valid && o_w2i_ready;
    out_fire_s  = o_w2i_valid && i_idu_ready;
    in_ent_s    = '{pc: i_wbu_pc, wr_en: i_wbu_reg_wr_en,
                    wr_id: i_wbu_reg_wr_id, wr_data: i_wbu_reg_wr_data};
  end

  // Next-state and entry-load logic for the EMPTY/BUSY/FULL skid buffer.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    case (state_r)
      EMPTY: begin
        if (in_fire_s) begin
          state_nxt_s = BUSY;
          main_nxt_s  = in_ent_s;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      BUSY: begin
        if (in_fire_s && out_fire_s) begin
          state_nxt_s = BUSY;
          main_nxt_s  = in_ent_s;
        end else if (in_fire_s) begin
          state_nxt_s = FULL;
          skid_nxt_s  = in_ent_s;
        end else if (out_fire_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      FULL: begin
        if (out_fire_s) begin
          state_nxt_s = BUSY;
          main_nxt_s  = skid_r;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
        main_nxt_s  = W2I_ENTRY_RST;
        skid_nxt_s  = W2I_ENTRY_RST;
      end
    endcase
  end

  // State and entry registers; reset discards any pending writes.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      state_r <= EMPTY;
      main_r  <= W2I_ENTRY_RST;
      skid_r  <= W2I_ENTRY_RST;
    end else begin
      state_r <= state_nxt_s;
      main_r  <= main_nxt_s;
      skid_r  <= skid_nxt_s;
    end
  end

  // Head entry fields come straight from the MAIN register.
  always_comb begin
    o_w2i_pc          = main_r.pc;
    o_w2i_reg_wr_en   = main_r.wr_en;
    o_w2i_reg_wr_id   = main_r.wr_id;
    o_w2i_reg_wr_data = main_r.wr_data;
  end

  w2i_fwd_sel u_fwd_rs1 (
    .rs_id        (i_idu_rs1_id),
    .main_vld     (main_vld_s),
    .main_wr_en   (main_r.wr_en),
    .main_wr_id   (main_r.wr_id),
    .main_wr_data (main_r.wr_data),
    .skid_vld     (skid_vld_s),
    .skid_wr_en   (skid_r.wr_en),
    .skid_wr_id   (skid_r.wr_id),
    .skid_wr_data (skid_r.wr_data),
    .hit          (o_w2i_rs1_hit),
    .data         (o_w2i_rs1_data)
  );

  w2i_fwd_sel u_fwd_rs2 (
    .rs_id        (i_idu_rs2_id),
    .main_vld     (main_vld_s),
    .main_wr_en   (main_r.wr_en),
    .main_wr_id   (main_r.wr_id),
    .main_wr_data (main_r.wr_data),
    .skid_vld     (skid_vld_s),
    .skid_wr_en   (skid_r.wr_en),
    .skid_wr_id   (skid_r.wr_id),
    .skid_wr_data (skid_r.wr_data),
    .hit          (o_w2i_rs2_hit),
    .data         (o_w2i_rs2_data)
  );

endmodule

// File: tb/tb_wbu2idu.sv
// Self-checking bench for wbu2idu: directed table, hand sequences, random vs queue model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 32'h8000_0000
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0000_0000
`endif

module tb_wbu2idu;

  localparam int RAW = 5;
  localparam int DWT = `DATA_WIDTH;
  localparam int AWT = `ADDR_WIDTH;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wbu_valid;
  logic            w2i_ready;
  logic [AWT-1:0]  wbu_pc;
  logic            wbu_en;
  logic [RAW-1:0]  wbu_id;
  logic [DWT-1:0]  wbu_data;
  logic            idu_ready;
  logic            w2i_valid;
  logic [AWT-1:0]  w2i_pc;
  logic            w2i_en;
  logic [RAW-1:0]  w2i_id;
  logic [DWT-1:0]  w2i_data;
  logic [RAW-1:0]  rs1_id, rs2_id;
  logic            rs1_hit, rs2_hit;
  logic [DWT-1:0]  rs1_data, rs2_data;

  always #5 clk = ~clk;

  wbu2idu dut (
    .i_sys_clk         (clk),
    .i_sys_rst_n       (rst_n),
    .i_wbu_valid       (wbu_valid),
    .o_w2i_ready       (w2i_ready),
    .i_wbu_pc          (wbu_pc),
    .i_wbu_reg_wr_en   (wbu_en),
    .i_wbu_reg_wr_id   (wbu_id),
    .i_wbu_reg_wr_data (wbu_data),
    .i_idu_ready       (idu_ready),
    .o_w2i_valid       (w2i_valid),
    .o_w2i_pc          (w2i_pc),
    .o_w2i_reg_wr_en   (w2i_en),
    .o_w2i_reg_wr_id   (w2i_id),
    .o_w2i_reg_wr_data (w2i_data),
    .i_idu_rs1_id      (rs1_id),
    .i_idu_rs2_id      (rs2_id),
    .o_w2i_rs1_hit     (rs1_hit),
    .o_w2i_rs2_hit     (rs2_hit),
    .o_w2i_rs1_data    (rs1_data),
    .o_w2i_rs2_data    (rs2_data)
  );

  // Reference model: a plain FIFO of at most two pending writes.
  typedef struct {
    logic [AWT-1:0] pc;
    logic           en;
    logic [RAW-1:0] id;
    logic [DWT-1:0] data;
  } ent_t;

  ent_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Directed table record: one cycle of stimulus and the expected pre-edge outputs.
  typedef struct {
    logic           wv;
    logic [RAW-1:0] id;
    logic [DWT-1:0] data;
    logic           ird;
    logic [RAW-1:0] rs2;
    logic           ev;
    logic           er;
    logic [DWT-1:0] ehead;
    logic           ehit2;
    logic [DWT-1:0] efd2;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Newest pending write to a nonzero register wins.
  task automatic model_fwd(input logic [RAW-1:0] rs, output logic hit, output logic [DWT-1:0] d);
    hit = 1'b0;
    d   = `DATA_ZERO;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!hit && q[i].en && q[i].id == rs && rs != '0) begin
        hit = 1'b1;
        d   = q[i].data;
      end
    end
  endtask

  // Drive one cycle of inputs, let them settle, compare everything against the model.
  task automatic drive(input logic wv, input logic [AWT-1:0] pc, input logic en,
                       input logic [RAW-1:0] id, input logic [DWT-1:0] data,
                       input logic ird, input logic [RAW-1:0] r1, input logic [RAW-1:0] r2);
    logic           h;
    logic [DWT-1:0] d;
    wbu_valid = wv; wbu_pc = pc; wbu_en = en; wbu_id = id; wbu_data = data;
    idu_ready = ird; rs1_id = r1; rs2_id = r2;
    #1;
    chk("valid", 64'(w2i_valid), 64'(q.size() != 0));
    chk("ready", 64'(w2i_ready), 64'(q.size() < 2));
    if (q.size() != 0) begin
      chk("head_pc",   64'(w2i_pc),   64'(q[0].pc));
      chk("head_en",   64'(w2i_en),   64'(q[0].en));
      chk("head_id",   64'(w2i_id),   64'(q[0].id));
      chk("head_data", 64'(w2i_data), 64'(q[0].data));
    end
    model_fwd(r1, h, d);
    chk("rs1_hit",  64'(rs1_hit),  64'(h));
    chk("rs1_data", 64'(rs1_data), 64'(d));
    model_fwd(r2, h, d);
    chk("rs2_hit",  64'(rs2_hit),  64'(h));
    chk("rs2_data", 64'(rs2_data), 64'(d));
  endtask

  // Take the clock edge and apply the handshake rules to the model.
  task automatic advance();
    bit   in_fire, out_fire;
    ent_t e;
    in_fire  = wbu_valid && (q.size() < 2);
    out_fire = idu_ready && (q.size() != 0);
    e.pc = wbu_pc; e.en = wbu_en; e.id = wbu_id; e.data = wbu_data;
    @(posedge clk);
    if (out_fire) void'(q.pop_front());
    if (in_fire) q.push_back(e);
    #1;
  endtask

  task automatic idle(input logic ird, input logic [RAW-1:0] r1, input logic [RAW-1:0] r2);
    drive(1'b0, '0, 1'b0, '0, '0, ird, r1, r2);
  endtask

  initial begin
    int out_cnt;
    vecs[0] = '{1'b1, 5'd3, 32'h11, 1'b0, 5'd3, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
    vecs[1] = '{1'b1, 5'd3, 32'h22, 1'b0, 5'd3, 1'b1, 1'b1, 32'h11, 1'b1, 32'h11};
    vecs[2] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd3, 1'b1, 1'b0, 32'h11, 1'b1, 32'h22};
    vecs[3] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 1'b1, 1'b0, 32'h11, 1'b1, 32'h22};
    vecs[4] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 1'b1, 1'b1, 32'h22, 1'b1, 32'h22};
    vecs[5] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};

    rst_n = 1'b0;
    wbu_valid = 1'b0; wbu_pc = '0; wbu_en = 1'b0; wbu_id = '0; wbu_data = '0;
    idu_ready = 1'b0; rs1_id = 5'd0; rs2_id = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(w2i_valid), 64'd0);
    chk("rst_ready", 64'(w2i_ready), 64'd1);
    chk("rst_pc",    64'(w2i_pc),    64'(`ADDR_INIT));
    chk("rst_en",    64'(w2i_en),    64'd0);
    chk("rst_id",    64'(w2i_id),    64'd0);
    chk("rst_data",  64'(w2i_data),  64'(`DATA_ZERO));
    chk("rst_hit1",  64'(rs1_hit),   64'd0);
    chk("rst_fd1",   64'(rs1_data),  64'(`DATA_ZERO));
    rst_n = 1'b1;

    // Single write, consumed immediately.
    drive(1'b1, 32'h8000_0004, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd5, 5'd0);
    advance();
    idle(1'b1, 5'd5, 5'd0);
    chk("single_valid", 64'(w2i_valid), 64'd1);
    chk("single_pc",    64'(w2i_pc),    64'h8000_0004);
    chk("single_data",  64'(w2i_data),  64'hDEAD_BEEF);
    chk("single_hit",   64'(rs1_hit),   64'd1);
    chk("single_fd",    64'(rs1_data),  64'hDEAD_BEEF);
    advance();
    idle(1'b1, 5'd5, 5'd0);
    chk("single_empty", 64'(w2i_valid), 64'd0);
    advance();

    // Stall/skid sequence from the table.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].wv, 32'h100 + 32'(i * 4), 1'b1, vecs[i].id, vecs[i].data,
            vecs[i].ird, 5'd0, vecs[i].rs2);
      chk($sformatf("vec%0d_valid", i), 64'(w2i_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d_ready", i), 64'(w2i_ready), 64'(vecs[i].er));
      if (vecs[i].ev) chk($sformatf("vec%0d_head", i), 64'(w2i_data), 64'(vecs[i].ehead));
      chk($sformatf("vec%0d_hit2", i), 64'(rs2_hit),  64'(vecs[i].ehit2));
      chk($sformatf("vec%0d_fd2", i),  64'(rs2_data), 64'(vecs[i].efd2));
      advance();
    end

    // Continuous stream of 8 writes with IDU always ready.
    out_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b1, 32'h2000 + 32'(i * 4), 1'b1, 5'(i + 1), 32'hA000 + 32'(i), 1'b1, 5'(i), 5'd0);
      else       idle(1'b1, 5'd0, 5'd0);
      chk("stream_ready", 64'(w2i_ready), 64'd1);
      if (i > 0) begin
        chk("stream_valid", 64'(w2i_valid), 64'd1);
        chk("stream_order", 64'(w2i_data), 64'hA000 + 64'(out_cnt));
        out_cnt++;
      end
      advance();
    end

    // x0 write passes through but never forwards.
    drive(1'b1, 32'h300, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0);
    advance();
    idle(1'b1, 5'd0, 5'd0);
    chk("x0_id",   64'(w2i_id),   64'd0);
    chk("x0_data", 64'(w2i_data), 64'h1234);
    chk("x0_hit",  64'(rs1_hit),  64'd0);
    chk("x0_fd",   64'(rs1_data), 64'd0);
    advance();

    // Non-writing entry passes through but never forwards.
    drive(1'b1, 32'h304, 1'b0, 5'd7, 32'h5555, 1'b0, 5'd7, 5'd7);
    advance();
    idle(1'b1, 5'd7, 5'd7);
    chk("noen_valid", 64'(w2i_valid), 64'd1);
    chk("noen_en",    64'(w2i_en),    64'd0);
    chk("noen_id",    64'(w2i_id),    64'd7);
    chk("noen_hit",   64'(rs1_hit),   64'd0);
    advance();

    // Fill to FULL, then reset for one cycle: nothing buffered may survive.
    drive(1'b1, 32'h400, 1'b1, 5'd9, 32'h99, 1'b0, 5'd9, 5'd10);
    advance();
    drive(1'b1, 32'h404, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd9, 5'd10);
    advance();
    idle(1'b0, 5'd9, 5'd10);
    chk("full_ready", 64'(w2i_ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    chk("midrst_valid", 64'(w2i_valid), 64'd0);
    chk("midrst_ready", 64'(w2i_ready), 64'd1);
    chk("midrst_hit1",  64'(rs1_hit),   64'd0);
    chk("midrst_hit2",  64'(rs2_hit),   64'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 5'd9, 5'd10);
      advance();
    end

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), 32'($urandom), 1'($urandom_range(0, 2) != 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wbu2idu.md
# wbu2idu

Writeback-to-decode return stage: carries retired register writes from WBU back to IDU's register file over a real valid/ready handshake. Holds up to two in-flight writes in a skid buffer so WBU is never stalled combinationally by IDU. Exposes a combinational forwarding lookup so IDU can read a pending write before it reaches the register file. Sits on the backward path of the pipeline, opposite in direction to the forward stage registers.

## Interface
- `REG_AW`, 5: register index width.
- Data, address and init widths and values use the codebase macros: `DATA_WIDTH`, `ADDR_WIDTH`, `ADDR_INIT`, `DATA_ZERO`.

Ports:
- `i_sys_clk`  in  1  system clock.
- `i_sys_rst_n`  in  1  reset; synchronous and active-low, on the single clock `i_sys_clk`.
- `i_wbu_valid`  in  1  WBU offers a write.
- `o_w2i_ready`  out  1  stage can accept.
- `i_wbu_pc`  in  `ADDR_WIDTH`  PC of the retiring instruction.
- `i_wbu_reg_wr_en`  in  1  instruction writes a register.
- `i_wbu_reg_wr_id`  in  `REG_AW`  destination register index.
- `i_wbu_reg_wr_data`  in  `DATA_WIDTH`  write data.
- `i_idu_ready`  in  1  IDU register file accepts.
- `o_w2i_valid`  out  1  head entry valid.
- `o_w2i_pc`, `o_w2i_reg_wr_en`, `o_w2i_reg_wr_id`, `o_w2i_reg_wr_data`  out  same widths as inputs  head entry fields.
- `i_idu_rs1_id`, `i_idu_rs2_id`  in  `REG_AW`  source indices being decoded.
- `o_w2i_rs1_hit`, `o_w2i_rs2_hit`  out  1  a pending write matches.
- `o_w2i_rs1_data`, `o_w2i_rs2_data`  out  `DATA_WIDTH`  forwarded data; `DATA_ZERO` when there is no hit.

## Operation
Handshake and storage:
- Input fire = `i_wbu_valid && o_w2i_ready`.
- Output fire = `o_w2i_valid && i_idu_ready`.
- Storage is two entries: MAIN, which drives the outputs, and SKID, which holds a newer entry.
- `o_w2i_ready` = (state != FULL), decoded from state only, with no combinational path from `i_idu_ready`.
- `o_w2i_valid` = (state != EMPTY).

State machine (EMPTY, BUSY, FULL):
- EMPTY: input fire -> BUSY, MAIN <= input.
- BUSY, input and output fire -> BUSY, MAIN <= input.
- BUSY, input only -> FULL, SKID <= input.
- BUSY, output only -> EMPTY.
- BUSY, neither -> hold.
- FULL, output fire -> BUSY, MAIN <= SKID. No input is possible in FULL because ready is 0.
- FULL, no output fire -> hold.

Payload rules:
- Entries with `reg_wr_en`=0 still pass through, because IDU uses them for retire tracking.
- Writes to x0 pass through unchanged.
- Fields are never modified. Order is strict FIFO.

Forwarding (combinational), evaluated for each of rs1 and rs2:
- Candidates: the SKID entry when FULL, and the MAIN entry when BUSY or FULL.
- A candidate qualifies when its `reg_wr_en`=1 AND `wr_id` == rs_id AND rs_id != 0.
- If SKID qualifies, it wins over MAIN (newest wins).
- hit=1 and data=winner's data; otherwise hit=0 and data=`DATA_ZERO`.

Reset behaviour:
- Reset mid-operation discards both entries; pending writes are lost by design.
- Stale payload in an invalid entry never produces a hit.

## Timing
- Reset values, from the first clock edge with `i_sys_rst_n`=0:
  - state EMPTY; `o_w2i_valid`=0; `o_w2i_ready`=1.
  - `o_w2i_pc`=`ADDR_INIT`; `o_w2i_reg_wr_en`=0; `o_w2i_reg_wr_id`=0; `o_w2i_reg_wr_data`=`DATA_ZERO`.
  - SKID cleared identically; all hits 0; forwarded data `DATA_ZERO`.
- Latency: input fire in cycle N -> `o_w2i_valid`=1 with that payload in N+1.
- Throughput: one entry per cycle when `i_idu_ready` is held at 1; the state stays BUSY.
- `o_w2i_ready` falls in the cycle after the second unconsumed accept.
- `o_w2i_ready` rises in the cycle after the FULL-state output fire.
- Output fields are stable while `o_w2i_valid`=1 and `i_idu_ready`=0.
- Forwarding outputs reflect the current registered state in the same cycle; they have no latency relative to `i_idu_rs*_id`.

## Structure
- Shared package `w2i_pkg`:
  - `w2i_state_e` enum (EMPTY, BUSY, FULL).
  - `w2i_entry_t` packed struct {pc, wr_en, wr_id, wr_data}.
  - Reset constant `W2I_ENTRY_RST`.
- Sub-module `w2i_fwd_sel`: combinational two-candidate compare and priority select. It is instantiated twice, once for rs1 and once for rs2.
- Top level holds the state register, the two entry registers and the handshake decode.

## Test plan
- Reset, then one write {pc=0x8000_0004, en=1, id=5, data=0xDEAD_BEEF} with `i_idu_ready`=1:
  - valid=1 with that payload one cycle after the fire; EMPTY the next cycle.
  - rs1_id=5 during BUSY -> hit=1, data=0xDEAD_BEEF.
- Stall with `i_idu_ready`=0 and writes id=3/0x11 then id=3/0x22:
  - ready=0 after the second accept.
  - rs2_id=3 -> data=0x22 (SKID wins).
  - Release -> outputs 0x11 then 0x22; ready=1 the cycle after the first output fire.
- Continuous stream of 8 writes with `i_idu_ready`=1 -> 8 outputs in order, one per cycle, ready never 0.
- Write to x0 with data 0x1234 -> passed through with id=0; rs1_id=0 -> hit=0, data=0.
- Entry with en=0, id=7 -> passed to output; rs1_id=7 -> hit=0.
- FULL state, then `i_sys_rst_n`=0 for one cycle -> valid=0, ready=1, all hits 0; no buffered entry is ever emitted.
